secure_storage_dbg_gated: RTL
=============================

Name: secure_storage_dbg_gated

Overview:
Parametrised word-addressed secure storage with a functional read/write port and a separate debug read port. Addresses at or above SECURE_BASE form a secret region. The debug port can read the secret region only after a key-authenticated unlock. Repeated failed unlocks trigger a sticky lockout and a hardware zeroization sweep of the secret region. The block sits between the system bus slave and the debug/JTAG bridge.

Parameters:
DATA_W, 32, word width in bits
ADDR_W, 8, address width; depth = 2**ADDR_W words
SECURE_BASE, 2**ADDR_W - 64, first address of the secret region (region runs to the top of memory)
DBG_KEY, 32'hA5C3_5A3C, unlock key compared against dbg_key (DATA_W bits)
MAX_FAIL, 3, failed unlock attempts that cause lockout (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wr_en  in  1  functional write strobe
rd_en  in  1  functional read strobe
addr  in  ADDR_W  functional address
wdata  in  DATA_W  functional write data
rdata  out  DATA_W  functional read data, registered
rvalid  out  1  rdata valid pulse
dbg_rd_en  in  1  debug read strobe
dbg_addr  in  ADDR_W  debug read address
dbg_rdata  out  DATA_W  debug read data, registered
dbg_rvalid  out  1  dbg_rdata valid pulse
dbg_err  out  1  debug read denied; pulses with dbg_rvalid
dbg_key_valid  in  1  unlock attempt strobe
dbg_key  in  DATA_W  unlock key
dbg_relock  in  1  return from UNLOCKED to LOCKED
dbg_unlocked  out  1  high in UNLOCKED
dbg_lockout  out  1  high in LOCKOUT (sticky until rst)
zeroize_busy  out  1  secret-region sweep in progress

Behaviour:
- Reset (synchronous): rdata=0, rvalid=0, dbg_rdata=0, dbg_rvalid=0, dbg_err=0, dbg_unlocked=0, dbg_lockout=0, zeroize_busy=0, fail_cnt=0, FSM=LOCKED. Memory contents are not cleared by rst. rst during a sweep aborts the sweep.
- Functional port: has no access restriction in non-sweep states.
  - Write takes effect at the clock edge.
  - Read has 1-cycle latency: rdata/rvalid appear the cycle after rd_en.
  - A read and write to the same address in the same cycle return the old data (read-first).
  - rvalid=0 in cycles without a prior rd_en. rdata holds its last value.
- Debug read: 1-cycle latency and read-first, independent of the functional port.
  - Address below SECURE_BASE: always returns data, dbg_err=0.
  - Address >= SECURE_BASE outside UNLOCKED: dbg_rdata=0, dbg_err=1. The memory word must never reach dbg_rdata.
- FSM states: LOCKED, CHECK, UNLOCKED, LOCKOUT.
  - LOCKED + dbg_key_valid: register the key and go to CHECK.
  - CHECK, key matches: go to UNLOCKED and set fail_cnt=0.
  - CHECK, key mismatches: fail_cnt+1. If the new count equals MAX_FAIL, go to LOCKOUT; otherwise go to LOCKED.
  - UNLOCKED + dbg_relock: go to LOCKED. dbg_key_valid is ignored in UNLOCKED.
  - LOCKOUT: terminal until rst. dbg_key_valid and dbg_relock are ignored.
  - dbg_key_valid in CHECK is ignored (one attempt in flight).
  - dbg_relock outside UNLOCKED is ignored.
- Outputs are driven from the state register: dbg_unlocked = (state==UNLOCKED), dbg_lockout = (state==LOCKOUT).
- Zeroization: starts in the cycle LOCKOUT is entered.
  - zeroize_busy rises on the first LOCKOUT cycle.
  - The sweep pointer starts at SECURE_BASE and writes 0 to one word per cycle.
  - zeroize_busy falls after writing address 2**ADDR_W-1, so it is high for 2**ADDR_W - SECURE_BASE cycles.
  - While busy:
    - Functional writes to the secret region are dropped.
    - Functional reads of the secret region return 0.
    - Non-secret accesses proceed normally.
  - After the sweep, functional access to the secret region resumes normally. The debug port remains denied for it.
- fail_cnt width is 4 bits. It saturates at MAX_FAIL and never wraps.

Test Plan:
1. Reset, write 0xDEADBEEF at 0x10 and 0x12345678 at 0xC5; functional read 0xC5 -> rdata=0x12345678 one cycle after rd_en, rvalid=1 for one cycle.
2. Debug read 0x10 -> 0xDEADBEEF, dbg_err=0; debug read 0xC5 while LOCKED -> dbg_rdata=0, dbg_err=1.
3. dbg_key=0xA5C35A3C -> dbg_unlocked=1 two cycles later; debug read 0xC5 -> 0x12345678, dbg_err=0; dbg_relock -> dbg_unlocked=0; read 0xC5 denied again.
4. Wrong key twice, then correct -> UNLOCKED and fail_cnt=0. Next, three wrong keys -> dbg_lockout=1 and zeroize_busy high exactly 64 cycles. Afterward, functional read 0xC5 -> 0; a correct key is ignored.
5. During the sweep, functional write 0xAAAA5555 to 0xD0 is dropped and a write to 0x20 succeeds. After reset, dbg_lockout=0, and memory 0x20 retains its value.
6. Simultaneous wr_en/rd_en at 0x30 (old 0x1, new 0x2) -> rdata=0x1, next read 0x2. Assert rst during the sweep at pointer 0xE0 -> busy=0, state LOCKED, and words 0xE0..0xFF retain prior data.

Source files
------------

// File: rtl/secure_storage_dbg_gated.sv
// Word-addressed storage with a functional port and a key-gated debug read port.
// Failed unlocks reaching MAX_FAIL cause a sticky lockout and a zeroization sweep of the secret region.
module secure_storage_dbg_gated #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 8,
  parameter int                SECURE_BASE = 2**ADDR_W - 64,
  parameter logic [DATA_W-1:0] DBG_KEY     = DATA_W'(32'hA5C3_5A3C),
  parameter int                MAX_FAIL    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              dbg_rd_en,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              dbg_err,
  input  logic              dbg_key_valid,
  input  logic [DATA_W-1:0] dbg_key,
  input  logic              dbg_relock,
  output logic              dbg_unlocked,
  output logic              dbg_lockout,
  output logic              zeroize_busy
);
  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SEC_BASE = ADDR_W'(SECURE_BASE);
  localparam logic [3:0]        MAX_F    = 4'(MAX_FAIL);

  typedef enum logic [1:0] {LOCKED, CHECK, UNLOCKED, LOCKOUT} state_t;

  state_t             state, state_nxt;
  logic [3:0]         fail_cnt, fail_nxt, fail_inc;
  logic [DATA_W-1:0]  key_q;
  logic [ADDR_W-1:0]  ptr;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic f_sec, d_sec, f_we, d_deny;
  assign f_sec  = (addr >= SEC_BASE);
  assign d_sec  = (dbg_addr >= SEC_BASE);
  // Functional writes into the secret region are dropped while the sweep runs.
  assign f_we   = wr_en && !(zeroize_busy && f_sec);
  assign d_deny = d_sec && (state != UNLOCKED);

  assign dbg_unlocked = (state == UNLOCKED);
  assign dbg_lockout  = (state == LOCKOUT);

  always_comb begin
    state_nxt = state;
    fail_nxt  = fail_cnt;
    fail_inc  = (fail_cnt >= MAX_F) ? MAX_F : fail_cnt + 4'd1;
    case (state)
      LOCKED:   if (dbg_key_valid) state_nxt = CHECK;
      CHECK: begin
        if (key_q == DBG_KEY) begin
          state_nxt = UNLOCKED;
          fail_nxt  = 4'd0;
        end else begin
          fail_nxt  = fail_inc;
          state_nxt = (fail_inc == MAX_F) ? LOCKOUT : LOCKED;
        end
      end
      UNLOCKED: if (dbg_relock) state_nxt = LOCKED;
      LOCKOUT:  state_nxt = LOCKOUT;
      default:  state_nxt = LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOCKED;
      fail_cnt     <= 4'd0;
      key_q        <= '0;
      zeroize_busy <= 1'b0;
      ptr          <= SEC_BASE;
    end else begin
      state    <= state_nxt;
      fail_cnt <= fail_nxt;
      if (state == LOCKED && dbg_key_valid) key_q <= dbg_key;
      // Sweep is armed on the transition so busy is high on the first LOCKOUT cycle.
      if (state_nxt == LOCKOUT && state != LOCKOUT) begin
        zeroize_busy <= 1'b1;
        ptr          <= SEC_BASE;
      end else if (zeroize_busy) begin
        ptr <= ptr + 1'b1;
        if (ptr == '1) zeroize_busy <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; rst only suppresses the sweep write.
  always_ff @(posedge clk) begin
    if (f_we) mem[addr] <= wdata;
    if (zeroize_busy && !rst) mem[ptr] <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata      <= '0;
      rvalid     <= 1'b0;
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
      dbg_err    <= 1'b0;
    end else begin
      rvalid     <= rd_en;
      dbg_rvalid <= dbg_rd_en;
      dbg_err    <= dbg_rd_en && d_deny;
      if (rd_en) rdata <= (zeroize_busy && f_sec) ? '0 : mem[addr];
      if (dbg_rd_en) dbg_rdata <= d_deny ? '0 : mem[dbg_addr];
    end
  end
endmodule
